// File: rtl/mem_arbiter2.sv
// Two-master arbiter for one single-ported, one-cycle-read-latency 32-bit memory.
// Define MEM_ARB_FAIR_EN for burst-bounded arbitration; otherwise m0 has fixed priority.
module mem_arbiter2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic                  m0_write,
  input  logic [3:0]            m0_wmask,
  input  logic [31:0]           m0_wdata,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic                  m1_write,
  input  logic [3:0]            m1_wmask,
  input  logic [31:0]           m1_wdata,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_M0,
    GNT_M1
  } gnt_e;

  gnt_e gnt;

  logic resp_pending_q, resp_pending_d;
  logic resp_owner_q, resp_owner_d;

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("mem_arbiter2: MAX_BURST must be in 1..15");
  end

`ifdef MEM_ARB_FAIR_EN
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  logic       last_q, last_d;
  logic [3:0] burst_q, burst_d;

  // On contention the last owner keeps the port until its run reaches BURST_MAX.
  always_comb begin
    gnt = GNT_NONE;
    if (m0_valid && m1_valid) begin
      if (burst_q < BURST_MAX) begin
        gnt = last_q ? GNT_M1 : GNT_M0;
      end else begin
        gnt = last_q ? GNT_M0 : GNT_M1;
      end
    end else if (m0_valid) begin
      gnt = GNT_M0;
    end else if (m1_valid) begin
      gnt = GNT_M1;
    end
  end

  always_comb begin
    last_d  = last_q;
    burst_d = '0;
    if (gnt != GNT_NONE) begin
      if ((gnt == GNT_M1) == last_q) begin
        burst_d = (burst_q < BURST_MAX) ? burst_q + 4'd1 : BURST_MAX;
      end else begin
        last_d  = (gnt == GNT_M1);
        burst_d = 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q  <= 1'b0;
      burst_q <= '0;
    end else begin
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end
`else
  always_comb begin
    gnt = GNT_NONE;
    if (m0_valid) begin
      gnt = GNT_M0;
    end else if (m1_valid) begin
      gnt = GNT_M1;
    end
  end
`endif

  always_comb begin
    m0_ready       = (gnt == GNT_M0);
    m1_ready       = (gnt == GNT_M1);
    mem_valid      = (gnt != GNT_NONE);
    mem_write      = 1'b0;
    mem_wmask      = '0;
    mem_wdata      = m0_wdata;
    mem_addr       = m0_addr;
    resp_pending_d = 1'b0;
    resp_owner_d   = resp_owner_q;
    case (gnt)
      GNT_M0: begin
        mem_write      = m0_write;
        mem_wmask      = m0_wmask;
        resp_pending_d = !m0_write;
        resp_owner_d   = 1'b0;
      end
      GNT_M1: begin
        mem_write      = m1_write;
        mem_wmask      = m1_wmask;
        mem_wdata      = m1_wdata;
        mem_addr       = m1_addr;
        resp_pending_d = !m1_write;
        resp_owner_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      resp_pending_q <= 1'b0;
      resp_owner_q   <= 1'b0;
    end else begin
      resp_pending_q <= resp_pending_d;
      resp_owner_q   <= resp_owner_d;
    end
  end

  assign m0_rvalid = resp_pending_q && !resp_owner_q;
  assign m1_rvalid = resp_pending_q && resp_owner_q;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule
